// File: rtl/shifter_unit.sv
// 32-bit registered barrel shifter: SLL, SRL, SRA and ROTR with one cycle of latency.
// All modes share one right-shifting log barrel; SLL bit-reverses around it.
module shifter_unit #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned SHW   = 5
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] data,
    input  logic [SHW-1:0]   num,
    input  logic [1:0]       shift_type,
    output logic [WIDTH-1:0] result,
    output logic             out_valid
);

    typedef enum logic [1:0] {
        ShSll  = 2'b00,
        ShSrl  = 2'b01,
        ShSra  = 2'b10,
        ShRotr = 2'b11
    } shift_e;

    localparam int W = WIDTH;

    logic                      is_left;
    logic                      is_rot;
    logic                      fill;
    logic [WIDTH-1:0]          reversed_in;
    logic [WIDTH-1:0]          barrel_out;
    logic [WIDTH-1:0]          shift_res;
    logic [SHW:0][WIDTH-1:0]   stage;

    always_comb begin
        is_left = (shift_e'(shift_type) == ShSll);
        is_rot  = (shift_e'(shift_type) == ShRotr);
        fill    = (shift_e'(shift_type) == ShSra) & data[WIDTH-1];

        reversed_in = '0;
        for (int i = 0; i < W; i++) begin
            reversed_in[i] = data[W-1-i];
        end

        stage    = '0;
        stage[0] = is_left ? reversed_in : data;
        // Stage s moves bits down by 2**s; bits falling off the top take the fill
        // bit, or wrap around from the bottom when rotating.
        for (int s = 0; s < SHW; s++) begin
            for (int i = 0; i < W; i++) begin
                if (!num[s]) begin
                    stage[s+1][i] = stage[s][i];
                end else if (i + (1 << s) < W) begin
                    stage[s+1][i] = stage[s][i + (1 << s)];
                end else begin
                    stage[s+1][i] = is_rot ? stage[s][i + (1 << s) - W] : fill;
                end
            end
        end

        barrel_out = stage[SHW];
        shift_res  = barrel_out;
        if (is_left) begin
            for (int i = 0; i < W; i++) begin
                shift_res[i] = barrel_out[W-1-i];
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            result    <= '0;
            out_valid <= 1'b0;
        end else begin
            out_valid <= in_valid;
            if (in_valid) begin
                result <= shift_res;
            end
        end
    end

endmodule

// File: tb/tb_shifter_unit.sv
// Self-checking bench for shifter_unit: directed cases plus a randomized sweep
// against an arithmetic reference model.
module tb_shifter_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic        in_valid;
    logic [31:0] data;
    logic [4:0]  num;
    logic [1:0]  shift_type;
    logic [31:0] result;
    logic        out_valid;

    int total  = 0;
    int failed = 0;

    shifter_unit #(
        .WIDTH (32),
        .SHW   (5)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .in_valid   (in_valid),
        .data       (data),
        .num        (num),
        .shift_type (shift_type),
        .result     (result),
        .out_valid  (out_valid)
    );

    always #5 clk = ~clk;

    // Reference: direct operator semantics, rotate via a doubled word.
    function automatic logic [31:0] model(input logic [31:0] d, input logic [4:0] n,
                                          input logic [1:0] t);
        logic [63:0] dbl;
        case (t)
            2'b00:   model = d << n;
            2'b01:   model = d >> n;
            2'b10:   model = 32'($signed(d) >>> n);
            default: begin
                dbl   = {d, d} >> n;
                model = dbl[31:0];
            end
        endcase
    endfunction

    task automatic check32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            failed++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic check1(input string tag, input logic obs, input logic exp);
        total++;
        assert (obs === exp) else begin
            failed++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    // Drive one valid operation, then check it one edge later.
    task automatic op(input string tag, input logic [31:0] d, input logic [4:0] n,
                      input logic [1:0] t, input logic [31:0] exp);
        @(negedge clk);
        in_valid   = 1'b1;
        data       = d;
        num        = n;
        shift_type = t;
        @(posedge clk);
        #1;
        check32(tag, result, exp);
        check1({tag, "_valid"}, out_valid, 1'b1);
    endtask

    initial begin
        logic [31:0] rd;
        logic [31:0] held;

        reset      = 1'b1;
        in_valid   = 1'b0;
        data       = 32'hDEADBEEF;
        num        = 5'd3;
        shift_type = 2'b00;
        #12;
        check32("reset_result", result, 32'h0);
        check1("reset_valid", out_valid, 1'b0);
        @(negedge clk);
        reset = 1'b0;

        // Back-to-back across all four modes.
        op("t1_sll",  32'hFFFF0005, 5'd2, 2'b00, 32'hFFFC0014);
        op("t2_srl",  32'hFFFF0005, 5'd2, 2'b01, 32'h3FFFC001);
        op("t2_sra",  32'hFFFF0005, 5'd2, 2'b10, 32'hFFFFC001);
        op("t2_rotr", 32'hFFFF0005, 5'd2, 2'b11, 32'h7FFFC001);

        op("t3_sll",  32'h80000001, 5'd31, 2'b00, 32'h80000000);
        op("t3_srl",  32'h80000001, 5'd31, 2'b01, 32'h00000001);
        op("t3_sra",  32'h80000001, 5'd31, 2'b10, 32'hFFFFFFFF);
        op("t3_rotr", 32'h80000001, 5'd31, 2'b11, 32'h00000003);

        for (int t = 0; t < 4; t++) begin
            op("t4_num0", 32'h12345678, 5'd0, 2'(t), 32'h12345678);
        end

        // in_valid low: out_valid drops, result holds.
        held = 32'h12345678;
        @(negedge clk);
        in_valid = 1'b0;
        data     = 32'hA5A5A5A5;
        num      = 5'd7;
        @(posedge clk);
        #1;
        check1("idle_valid", out_valid, 1'b0);
        check32("idle_hold", result, held);

        // Asynchronous reset mid-stream.
        op("pre_reset", 32'h0000F00F, 5'd4, 2'b00, 32'h000F00F0);
        @(negedge clk);
        #2;
        reset = 1'b1;
        #1;
        check32("async_reset_result", result, 32'h0);
        check1("async_reset_valid", out_valid, 1'b0);
        @(negedge clk);
        reset    = 1'b0;
        in_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check1("post_reset_idle_valid", out_valid, 1'b0);
        check32("post_reset_idle_result", result, 32'h0);
        op("post_reset_first", 32'h00000001, 5'd1, 2'b11, 32'h80000000);

        // Every mode x every shift amount, with MSB both clear and set.
        for (int t = 0; t < 4; t++) begin
            for (int n = 0; n < 32; n++) begin
                for (int m = 0; m < 2; m++) begin
                    rd     = $urandom;
                    rd[31] = m[0];
                    op("rand", rd, 5'(n), 2'(t), model(rd, 5'(n), 2'(t)));
                end
            end
        end

        @(negedge clk);
        in_valid = 1'b0;
        @(posedge clk);
        #1;
        check1("final_idle_valid", out_valid, 1'b0);

        $display("%0d/%0d checks passed", total - failed, total);
        $finish;
    end

endmodule
